costas_acq_ctrl: RTL

//  Acquisition/lock controller for the Costas carrier-recovery loop. Takes the LPF'd I/Q arm outputs,

---
 rtl/costas_ctrl_pkg.sv | 19 +
 rtl/costas_win_acc.sv | 73 +++++++
 rtl/costas_acq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/costas_ctrl_pkg.sv
// Shared encodings for the Costas acquisition controller.
//   state_e : FSM state codes, also driven out on the debug state port.
//   gain_e  : loop-filter gain select codes driven on gain_sel.
package costas_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSweep = 3'd1,
    StPull  = 3'd2,
    StTrack = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    GainNone   = 2'd0,
    GainNarrow = 2'd1,
    GainWide   = 2'd2
  } gain_e;

endpackage

// File: rtl/costas_win_acc.sv
// Lock-quality window accumulator for the Costas acquisition controller.
// Sums |I| and |Q| over 2^WIN_LOG2 valid samples and judges the window on its last sample.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clr           synchronous clear of accumulators and sample counter (window restart)
//   i_valid         i_di/i_dq valid this cycle
//   i_di, i_dq      signed I/Q arm samples
//   o_eval          high in the cycle carrying the last sample of a window
//   o_good          window verdict, meaningful while o_eval is high
module costas_win_acc
  import costas_ctrl_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned WIN_LOG2  = 10,
  parameter int unsigned THR_SHIFT = 2,
  parameter int unsigned MIN_AMP   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_di,
  input  logic signed [DW-1:0] i_dq,
  output logic                 o_eval,
  output logic                 o_good
);

  localparam int unsigned AW      = DW + WIN_LOG2;
  localparam logic [AW-1:0] MinAcc  = AW'(MIN_AMP) << WIN_LOG2;
  localparam logic [DW-1:0] MostNeg = {1'b1, {(DW-1){1'b0}}};

  logic [AW-1:0]       r_acc_i, r_acc_q;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [DW-1:0]       w_neg_i, w_neg_q;
  logic [DW-2:0]       w_abs_i, w_abs_q;
  logic [AW-1:0]       w_sum_i, w_sum_q;
  logic                w_first;

  always_comb begin
    w_neg_i = -i_di;
    w_neg_q = -i_dq;
    // The most negative code has no positive twin; clamp it to the largest magnitude.
    if (i_di == MostNeg)  w_abs_i = '1;
    else if (i_di[DW-1])  w_abs_i = w_neg_i[DW-2:0];
    else                  w_abs_i = i_di[DW-2:0];
    if (i_dq == MostNeg)  w_abs_q = '1;
    else if (i_dq[DW-1])  w_abs_q = w_neg_q[DW-2:0];
    else                  w_abs_q = i_dq[DW-2:0];
    // First sample of a window loads instead of adding to the previous window's total.
    w_first = (r_cnt == '0);
    w_sum_i = (w_first ? '0 : r_acc_i) + AW'(w_abs_i);
    w_sum_q = (w_first ? '0 : r_acc_q) + AW'(w_abs_q);
    o_eval  = i_valid && !i_clr && (r_cnt == '1);
    o_good  = (w_sum_q < (w_sum_i >> THR_SHIFT)) && (w_sum_i >= MinAcc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_acc_i <= w_sum_i;
      r_acc_q <= w_sum_q;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/costas_acq_ctrl.sv
// Acquisition/lock controller for the Costas carrier-recovery loop.
// Judges lock quality per window and steps IDLE -> (SWEEP) -> PULL -> TRACK.
// Build option: define COSTAS_SWEEP_EN to include the SWEEP state and zigzag frequency
// search; without it en goes straight to PULL and freq_off stays 0.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   en                  1 = run acquisition, 0 = force IDLE
//   sample_valid, di, dq  LPF'd I/Q arm samples
//   freq_off            signed offset added to the loop-filter frequency word
//   gain_sel            0 none, 1 narrow (track), 2 wide (pull-in)
//   loop_hold           freeze loop-filter integrator, force its output to 0
//   locked              carrier lock flag
//   state               FSM state code (debug)
//   win_stb             one-cycle pulse per evaluated window
module costas_acq_ctrl
  import costas_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned FW         = 32,
  parameter int unsigned WIN_LOG2   = 10,
  parameter int unsigned THR_SHIFT  = 2,
  parameter int unsigned MIN_AMP    = 64,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned LOST_CNT   = 2,
  parameter int unsigned SWEEP_STEP = 4295,
  parameter int unsigned SWEEP_MAX  = 429497
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 en,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] di,
  input  logic signed [DW-1:0] dq,
  output logic signed [FW-1:0] freq_off,
  output logic [1:0]           gain_sel,
  output logic                 loop_hold,
  output logic                 locked,
  output logic [2:0]           state,
  output logic                 win_stb
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(LOST_CNT + 1);
  localparam logic signed [FW-1:0] SweepStep = FW'(SWEEP_STEP);
  localparam logic signed [FW-1:0] SweepMax  = FW'(SWEEP_MAX);

  state_e        r_state;
  gain_e         r_gain;
  logic          r_hold, r_locked, r_stb;
  logic [GW-1:0] r_good_cnt, w_good_inc;
  logic [BW-1:0] r_bad_cnt, w_bad_inc;
  logic          w_clr, w_eval, w_good;

  // Accumulation only runs while acquiring; IDLE or en low restarts the window.
  assign w_clr      = !en || (r_state == StIdle);
  assign w_good_inc = r_good_cnt + 1'b1;
  assign w_bad_inc  = r_bad_cnt + 1'b1;

  costas_win_acc #(
    .DW       (DW),
    .WIN_LOG2 (WIN_LOG2),
    .THR_SHIFT(THR_SHIFT),
    .MIN_AMP  (MIN_AMP)
  ) u_win (
    .i_clk  (sys_clk),
    .i_rst_n(sys_rst_n),
    .i_clr  (w_clr),
    .i_valid(sample_valid),
    .i_di   (di),
    .i_dq   (dq),
    .o_eval (w_eval),
    .o_good (w_good)
  );

`ifdef COSTAS_SWEEP_EN
  logic signed [FW-1:0] r_freq_off, w_zz_up, w_zz_next;

  // Zigzag 0,+S,-S,+2S,-2S,...; wraps to 0 once the next magnitude exceeds SweepMax.
  always_comb begin
    w_zz_up = SweepStep - r_freq_off;
    if (r_freq_off > 0)          w_zz_next = -r_freq_off;
    else if (w_zz_up > SweepMax) w_zz_next = '0;
    else                         w_zz_next = w_zz_up;
  end

  assign freq_off = r_freq_off;
`else
  logic w_unused_sweep;
  assign w_unused_sweep = ^{SweepStep, SweepMax};
  assign freq_off       = '0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= StIdle;
      r_gain     <= GainNone;
      r_hold     <= 1'b1;
      r_locked   <= 1'b0;
      r_stb      <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
`ifdef COSTAS_SWEEP_EN
      r_freq_off <= '0;
`endif
    end else if (!en) begin
      r_state    <= StIdle;
      r_gain     <= GainNone;
      r_hold     <= 1'b1;
      r_locked   <= 1'b0;
      r_stb      <= 1'b0;
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
`ifdef COSTAS_SWEEP_EN
      r_freq_off <= '0;
`endif
    end else begin
      // w_eval is already gated off in IDLE, so no strobe there.
      r_stb <= w_eval;
      unique case (r_state)
        StIdle: begin
`ifdef COSTAS_SWEEP_EN
          r_state <= StSweep;
`else
          r_state    <= StPull;
          r_gain     <= GainWide;
          r_hold     <= 1'b0;
          r_good_cnt <= '0;
`endif
        end
`ifdef COSTAS_SWEEP_EN
        StSweep: begin
          if (w_eval) begin
            if (w_good) begin
              r_state    <= StPull;
              r_gain     <= GainWide;
              r_hold     <= 1'b0;
              r_good_cnt <= GW'(1);
            end else begin
              r_freq_off <= w_zz_next;
            end
          end
        end
`endif
        StPull: begin
          if (w_eval) begin
            if (w_good) begin
              r_good_cnt <= w_good_inc;
              if (w_good_inc == GW'(LOCK_CNT)) begin
                r_state   <= StTrack;
                r_gain    <= GainNarrow;
                r_locked  <= 1'b1;
                r_bad_cnt <= '0;
              end
            end else begin
              r_good_cnt <= '0;
`ifdef COSTAS_SWEEP_EN
              r_state    <= StSweep;
              r_gain     <= GainNone;
              r_hold     <= 1'b1;
              r_freq_off <= w_zz_next;
`endif
            end
          end
        end
        StTrack: begin
          if (w_eval) begin
            if (w_good) begin
              r_bad_cnt <= '0;
            end else if (w_bad_inc == BW'(LOST_CNT)) begin
              r_state    <= StPull;
              r_gain     <= GainWide;
              r_locked   <= 1'b0;
              r_good_cnt <= '0;
              r_bad_cnt  <= '0;
            end else begin
              r_bad_cnt <= w_bad_inc;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gain_sel  = r_gain;
  assign loop_hold = r_hold;
  assign locked    = r_locked;
  assign state     = r_state;
  assign win_stb   = r_stb;

endmodule
